// File: rtl/cordic_vec_controller.sv
// Sequencing controller for the CORDIC vectoring-mode datapath: drives the
// x/y/z load enables and init mux select, supplies the iteration index and
// the per-iteration rotation direction, and handles start/ready/done.
module cordic_vec_controller #(
    parameter int unsigned NUM_ITER  = 16,
    parameter int unsigned CNT_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 y_sign,
    output logic                 init_sel,
    output logic                 ld_x,
    output logic                 ld_y,
    output logic                 ld_z,
    output logic                 dir,
    output logic [CNT_WIDTH-1:0] iter,
    output logic                 ready,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ITER = 2'd2,
        DONE = 2'd3
    } state_t;

    // Last iteration index; DONE is entered from here so iter never wraps.
    localparam logic [CNT_WIDTH-1:0] LAST_ITER = CNT_WIDTH'(NUM_ITER - 1);

    state_t state;
    logic   ld;
    logic   in_iter;

    // One shared enable drives all three datapath registers.
    assign ld_x = ld;
    assign ld_y = ld;
    assign ld_z = ld;

    // Rotation direction follows the live y sign, but only while iterating.
    assign dir = in_iter & ~y_sign;

    // State, counter and registered Moore outputs, updated for the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            iter     <= '0;
            ready    <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            init_sel <= 1'b0;
            ld       <= 1'b0;
            in_iter  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= LOAD;
                        iter     <= '0;
                        ready    <= 1'b0;
                        busy     <= 1'b1;
                        init_sel <= 1'b1;
                        ld       <= 1'b1;
                    end
                end
                LOAD: begin
                    state    <= ITER;
                    init_sel <= 1'b0;
                    in_iter  <= 1'b1;
                end
                ITER: begin
                    if (abort) begin
                        state   <= IDLE;
                        iter    <= '0;
                        ready   <= 1'b1;
                        busy    <= 1'b0;
                        ld      <= 1'b0;
                        in_iter <= 1'b0;
                    end else if (iter == LAST_ITER) begin
                        state   <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        ld      <= 1'b0;
                        in_iter <= 1'b0;
                    end else begin
                        iter <= iter + CNT_WIDTH'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    iter  <= '0;
                    done  <= 1'b0;
                    ready <= 1'b1;
                end
                default: begin
                    state    <= IDLE;
                    iter     <= '0;
                    ready    <= 1'b1;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                    init_sel <= 1'b0;
                    ld       <= 1'b0;
                    in_iter  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/cordic_vec_controller.md
Name: cordic_vec_controller

Overview:
Sequencing controller for the CORDIC vectoring-mode datapath. It drives the load enables of the x, y and z registers and the initial-value mux select. It supplies the iteration index used as shift amount and arctan-LUT address, and the per-iteration rotation direction taken from the sign of y. It provides a start/ready/done handshake to the surrounding system and sits beside the datapath registers in the CORDIC top level.

Parameters:
NUM_ITER, 16, number of micro-rotations per operation (2 to 2^CNT_WIDTH).
CNT_WIDTH, 4, width of the iteration counter and iter output.

Ports:
clk  input  1  system clock, rising-edge active.
rst  input  1  asynchronous, active-high reset.
start  input  1  request a new operation; sampled only in IDLE.
abort  input  1  synchronous cancel; returns to IDLE without done.
y_sign  input  1  MSB of current y register output (1 = negative).
init_sel  output  1  1 = datapath register muxes select external x0/y0/z0=0.
ld_x  output  1  load enable, x register.
ld_y  output  1  load enable, y register.
ld_z  output  1  load enable, z register.
dir  output  1  1 = y>=0 (x+=y>>i, y-=x>>i, z+=atan_i); 0 = opposite.
iter  output  CNT_WIDTH  current iteration index i.
ready  output  1  high in IDLE only.
busy  output  1  high in LOAD and ITER.
done  output  1  one-cycle pulse; x/z registers hold final magnitude/angle.

Behaviour:
- Reset (async, any state): state=IDLE, iter=0. Outputs: ready=1, busy=0, done=0, init_sel=0, ld_x/ld_y/ld_z=0, dir=0.
- Outputs are Moore-decoded from the state and counter registers. dir is y_sign inverted, gated to 0 outside ITER.
- States: IDLE, LOAD, ITER, DONE.
- IDLE: ready=1, all loads 0. start=1 at a rising edge moves to LOAD; otherwise stay.
- LOAD (exactly 1 cycle): init_sel=1, ld_x=ld_y=ld_z=1, busy=1, iter=0. Always moves to ITER; abort is ignored here.
- ITER: init_sel=0, ld_x=ld_y=ld_z=1, busy=1, dir=~y_sign.
  - Each edge with iter<NUM_ITER-1: iter increments by 1.
  - Edge with iter==NUM_ITER-1: move to DONE, iter holds.
- DONE (exactly 1 cycle): done=1, loads 0, busy=0, ready=0. Moves to IDLE and clears iter to 0.
- Latency: with start sampled at the edge ending cycle 0:
  - LOAD occupies cycle 1.
  - ITER occupies cycles 2 to NUM_ITER+1.
  - done is high in cycle NUM_ITER+2 (cycle 18 for the default).
  - ready returns in cycle NUM_ITER+3.
- start while busy or in DONE is ignored and not queued.
- start held high continuously: one operation per NUM_ITER+3 cycles, back to back.
- abort=1 at an edge while in ITER:
  - Next state is IDLE and iter=0; no done pulse.
  - Datapath register contents are left undefined to the consumer.
- abort in IDLE or DONE has no effect. If start and abort are both high in IDLE, start wins.
- Reset asserted mid-operation immediately forces all loads low and done low. There is no partial completion; the operation restarts only on a new start.
- iter never exceeds NUM_ITER-1. The counter does not wrap when NUM_ITER=2^CNT_WIDTH, because the DONE transition occurs before any increment past the top value.

Test Plan:
- Reset then idle: assert rst for 1 cycle, release, hold start=0 for 5 cycles -> ready=1, busy=0, done=0, all ld=0, iter=0 throughout.
- Nominal operation, NUM_ITER=16: pulse start 1 cycle ->
  - cycle 1: init_sel=1 and all ld=1;
  - cycles 2-17: iter=0..15 and init_sel=0;
  - cycle 18: single done pulse;
  - cycle 19: ready=1.
- Direction: drive y_sign=0 for iterations 0-3, then 1 for iterations 4-15 -> dir=1 for 4 cycles, then 0. dir=0 in IDLE, LOAD and DONE regardless of y_sign.
- Ignored start: pulse start again at iteration 5 -> no restart, done still in cycle 18. Hold start high continuously -> next LOAD in cycle 20.
- Abort: assert abort at iteration 7 -> IDLE next cycle, iter=0, no done pulse. A subsequent start runs a full 16 iterations.
- Async reset mid-op: assert rst between clock edges at iteration 10 -> outputs return to reset values immediately, before the next edge. No done pulse follows.
